// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch resolver.
// Branch funct3 encodings, the registered result record and the sequential PC step.
package branch_resolver_pkg;

    // Widest PC the result record can carry; the top zero-extends narrower PCs into it.
    localparam int RES_W = 64;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [RES_W-1:0] PC_STEP = 64'd4;

    typedef struct packed {
        logic             taken;
        logic             redirect;
        logic [RES_W-1:0] next_pc;
        logic             illegal;
    } result_t;

endpackage

// File: rtl/branch_skid_buffer.sv
// Two-entry FIFO carrying resolved branch results towards fetch.
// Head entry is the registered output; in_ready and out_valid are registered
// from the next occupancy, so out_ready never reaches in_ready combinationally.
module branch_skid_buffer
    import branch_resolver_pkg::*;
#(
    parameter type T = result_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    T           head_r;
    T           tail_r;
    logic [1:0] count_r;
    logic       in_ready_r;
    logic       out_valid_r;

    T           head_s;
    T           tail_s;
    logic [1:0] count_s;
    logic       push_s;
    logic       pop_s;

    assign push_s = in_valid & in_ready_r;
    assign pop_s  = out_valid_r & out_ready;

    // Next occupancy and entry contents; flush wins over push and pop.
    always_comb begin
        head_s  = head_r;
        tail_s  = tail_r;
        count_s = count_r;
        if (flush) begin
            head_s  = '0;
            count_s = 2'd0;
        end else begin
            case (count_r)
                2'd0: begin
                    if (push_s) begin
                        head_s  = in_data;
                        count_s = 2'd1;
                    end else begin
                        count_s = 2'd0;
                    end
                end
                2'd1: begin
                    if (push_s && pop_s) begin
                        head_s = in_data;
                    end else if (push_s) begin
                        tail_s  = in_data;
                        count_s = 2'd2;
                    end else if (pop_s) begin
                        // Clear the head so idle outputs read as zero.
                        head_s  = '0;
                        count_s = 2'd0;
                    end else begin
                        count_s = 2'd1;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        head_s  = tail_r;
                        count_s = 2'd1;
                    end else begin
                        count_s = 2'd2;
                    end
                end
                default: begin
                    // Unreachable occupancy: recover to empty.
                    head_s  = '0;
                    count_s = 2'd0;
                end
            endcase
        end
    end

    // Occupancy, entries and registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r      <= '0;
            tail_r      <= '0;
            count_r     <= 2'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            head_r      <= head_s;
            tail_r      <= tail_s;
            count_r     <= count_s;
            in_ready_r  <= (count_s < 2'd2);
            out_valid_r <= (count_s != 2'd0);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = head_r;

endmodule

// File: rtl/branch_resolver.sv
// Conditional branch resolver: decodes taken/not-taken from flagger flags per
// funct3, forms the next PC and hands a registered result to fetch through a
// two-entry skid buffer. Static predict-not-taken, so every taken branch redirects.
// Optional build macro BRANCH_RESOLVER_STATS_EN adds saturating transfer counters.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int WORDSIZE = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          funct3,
    input  logic [WORDSIZE-1:0] pc,
    input  logic [WORDSIZE-1:0] imm,
    input  logic                flag_equal,
    input  logic                flag_not_equal,
    input  logic                flag_greater,
    input  logic                flag_less,
    input  logic                flag_u_equal,
    input  logic                flag_u_greater,
    input  logic                flag_u_less,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_taken,
    output logic                out_redirect,
    output logic [WORDSIZE-1:0] out_next_pc,
    output logic                out_illegal
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_taken
`endif
);

    logic                cond_s;
    logic                illegal_s;
    logic [WORDSIZE-1:0] target_s;
    logic [WORDSIZE-1:0] seq_pc_s;
    result_t             in_res_s;
    result_t             out_res_s;

    // Branch condition from the flags relevant to each funct3; other flags are ignored.
    always_comb begin
        cond_s    = 1'b0;
        illegal_s = 1'b0;
        case (funct3)
            F3_BEQ:  cond_s = flag_equal;
            F3_BNE:  cond_s = flag_not_equal;
            F3_BLT:  cond_s = flag_less;
            F3_BGE:  cond_s = flag_greater | flag_equal;
            F3_BLTU: cond_s = flag_u_less;
            F3_BGEU: cond_s = flag_u_greater | flag_u_equal;
            default: begin
                cond_s    = 1'b0;
                illegal_s = 1'b1;
            end
        endcase
    end

    // Both adders wrap silently modulo 2^WORDSIZE.
    assign target_s = pc + imm;
    assign seq_pc_s = pc + WORDSIZE'(PC_STEP);

    // Assemble the result record entering the buffer.
    always_comb begin
        in_res_s          = '0;
        in_res_s.taken    = cond_s;
        in_res_s.redirect = cond_s & ~illegal_s;
        in_res_s.illegal  = illegal_s;
        if (cond_s) begin
            in_res_s.next_pc = RES_W'(target_s);
        end else begin
            in_res_s.next_pc = RES_W'(seq_pc_s);
        end
    end

    branch_skid_buffer #(
        .T (result_t)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_res_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_res_s)
    );

    assign out_taken    = out_res_s.taken;
    assign out_redirect = out_res_s.redirect;
    assign out_next_pc  = out_res_s.next_pc[WORDSIZE-1:0];
    assign out_illegal  = out_res_s.illegal;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] stat_branches_r;
    logic [31:0] stat_taken_r;

    // Saturating counts of output transfers; cleared by reset only, flush suppresses a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_r <= 32'd0;
            stat_taken_r    <= 32'd0;
        end else if (out_valid && out_ready && !flush) begin
            if (stat_branches_r != 32'hFFFF_FFFF) begin
                stat_branches_r <= stat_branches_r + 32'd1;
            end
            if (out_taken && (stat_taken_r != 32'hFFFF_FFFF)) begin
                stat_taken_r <= stat_taken_r + 32'd1;
            end
        end
    end

    assign stat_branches = stat_branches_r;
    assign stat_taken    = stat_taken_r;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Testbench for branch_resolver: directed scenarios followed by random traffic,
// checked against an operand-level model with a FIFO queue of expected results.
module tb_branch_resolver;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   funct3 = 3'b000;
    logic [W-1:0] pc = '0;
    logic [W-1:0] imm = '0;
    logic         flag_equal = 1'b0, flag_not_equal = 1'b0, flag_greater = 1'b0, flag_less = 1'b0;
    logic         flag_u_equal = 1'b0, flag_u_greater = 1'b0, flag_u_less = 1'b0;
    logic         in_ready, out_valid, out_taken, out_redirect, out_illegal;
    logic [W-1:0] out_next_pc;
`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0]  stat_branches, stat_taken;
`endif

    always #5 clk = ~clk;

    branch_resolver #(.WORDSIZE(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .pc(pc), .imm(imm),
        .flag_equal(flag_equal), .flag_not_equal(flag_not_equal),
        .flag_greater(flag_greater), .flag_less(flag_less),
        .flag_u_equal(flag_u_equal), .flag_u_greater(flag_u_greater), .flag_u_less(flag_u_less),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_redirect(out_redirect),
        .out_next_pc(out_next_pc), .out_illegal(out_illegal)
`ifdef BRANCH_RESOLVER_STATS_EN
        , .stat_branches(stat_branches), .stat_taken(stat_taken)
`endif
    );

    typedef struct {
        logic         taken;
        logic         illegal;
        logic [W-1:0] npc;
    } exp_t;

    int          compared = 0;
    int          mismatched = 0;
    exp_t        q[$];
    exp_t        cur;
    int unsigned m_branches = 0;
    int unsigned m_taken = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a branch comparing operands a and b; flags and expectation follow ISA semantics.
    task automatic present(input logic [2:0] f3, input logic [W-1:0] p, input logic [W-1:0] i,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        logic t;
        funct3         = f3;
        pc             = p;
        imm            = i;
        flag_equal     = (a == b);
        flag_not_equal = (a != b);
        flag_greater   = ($signed(a) > $signed(b));
        flag_less      = ($signed(a) < $signed(b));
        flag_u_equal   = (a == b);
        flag_u_greater = (a > b);
        flag_u_less    = (a < b);
        case (f3)
            3'b000:  t = (a == b);
            3'b001:  t = (a != b);
            3'b100:  t = ($signed(a) < $signed(b));
            3'b101:  t = ($signed(a) >= $signed(b));
            3'b110:  t = (a < b);
            3'b111:  t = (a >= b);
            default: t = 1'b0;
        endcase
        cur.taken   = t;
        cur.illegal = (f3 == 3'b010) || (f3 == 3'b011);
        cur.npc     = t ? (p + i) : (p + 64'd4);
        in_valid    = 1'b1;
    endtask

    task automatic check_outputs();
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("taken", 64'(out_taken), 64'(q[0].taken));
            chk("redirect", 64'(out_redirect), 64'(q[0].taken & ~q[0].illegal));
            chk("illegal", 64'(out_illegal), 64'(q[0].illegal));
            chk("next_pc", out_next_pc, q[0].npc);
        end else begin
            chk("idle_next_pc", out_next_pc, 64'd0);
            chk("idle_taken", 64'(out_taken), 64'd0);
        end
`ifdef BRANCH_RESOLVER_STATS_EN
        chk("stat_branches", 64'(stat_branches), 64'(m_branches));
        chk("stat_taken", 64'(stat_taken), 64'(m_taken));
`endif
    endtask

    // Check, then advance one clock and update the model with this cycle's transfers.
    task automatic step(output bit acc);
        bit drain;
        check_outputs();
        acc   = in_valid && (q.size() < 2) && !flush;
        drain = (q.size() > 0) && out_ready && !flush;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (drain) begin
                m_branches++;
                if (q[0].taken) m_taken++;
                void'(q.pop_front());
            end
            if (acc) q.push_back(cur);
        end
        #1;
    endtask

    initial begin
        bit           acc;
        bit           held;
        int           tries;
        logic [12:0]  r13;
        logic [W-1:0] a, b;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        out_ready = 1'b1;

        // BEQ taken
        present(3'b000, 64'h1000, 64'h20, 64'd5, 64'd5);
        step(acc);
        in_valid = 1'b0;
        step(acc);
        // BLT not taken, then BGEU taken with equal operands, back to back
        present(3'b100, 64'h2000, -64'sd8, 64'd5, 64'd3);
        step(acc);
        present(3'b111, 64'h2000, -64'sd8, 64'd9, 64'd9);
        step(acc);
        in_valid = 1'b0;
        step(acc);
        step(acc);
        // Illegal funct3
        present(3'b010, 64'h3000, 64'h40, 64'd1, 64'd1);
        step(acc);
        in_valid = 1'b0;
        step(acc);
        // PC wrap-around on a taken BNE
        present(3'b001, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 64'd1, 64'd2);
        step(acc);
        in_valid = 1'b0;
        step(acc);
        // Inconsistent flags on BLT: only flag_less matters
        present(3'b100, 64'h4000, 64'h100, 64'd7, 64'd7);
        flag_less    = 1'b1;
        flag_greater = 1'b1;
        cur.taken    = 1'b1;
        cur.npc      = 64'h4100;
        step(acc);
        in_valid = 1'b0;
        step(acc);
        step(acc);

        // Back-pressure: three branches A, B, C with fetch stalled
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            present(3'b000, 64'h5000 + 64'(k * 16), 64'h80, 64'(k), 64'd1);
            tries = 0;
            acc = 1'b0;
            while (!acc && tries < 8) begin
                step(acc);
                tries++;
                if (tries == 3) out_ready = 1'b1;
            end
            if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
        repeat (4) step(acc);

        // Flush while full, with a same-cycle input that must be dropped
        out_ready = 1'b0;
        present(3'b001, 64'h6000, 64'h10, 64'd1, 64'd2);
        step(acc);
        present(3'b001, 64'h6100, 64'h10, 64'd1, 64'd2);
        step(acc);
        present(3'b000, 64'h6200, 64'h10, 64'd3, 64'd3);
        flush = 1'b1;
        step(acc);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step(acc);

        // Random traffic
        held = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!held) begin
                if ($urandom_range(3) != 0) begin
                    a = {$urandom, $urandom};
                    b = ($urandom_range(3) == 0) ? a : {$urandom, $urandom};
                    r13 = 13'($urandom) & 13'h1FFE;
                    present(3'($urandom_range(7)), {$urandom, $urandom},
                            {{51{r13[12]}}, r13}, a, b);
                end else begin
                    in_valid = 1'b0;
                end
            end
            flush = ($urandom_range(15) == 0);
            out_ready = ($urandom_range(2) != 0);
            step(acc);
            held = in_valid && !acc && !flush;
        end
        flush = 1'b0;
        in_valid = 1'b0;

        // Asynchronous reset while full
        out_ready = 1'b0;
        present(3'b000, 64'h7000, 64'h20, 64'd4, 64'd4);
        step(acc);
        present(3'b000, 64'h7100, 64'h20, 64'd4, 64'd4);
        step(acc);
        in_valid = 1'b0;
        check_outputs();
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_branches = 0;
        m_taken = 0;
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) step(acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Consumes the comparison flags produced by the processor's flagger for a conditional branch and decides taken / not-taken per RISC-V funct3.
- Computes the branch target and next PC, then hands a registered result to the fetch/PC-update stage over a valid/ready handshake.
- A 2-entry skid buffer decouples the execute stage from fetch back-pressure.
- Static predict-not-taken: every taken branch raises a redirect.

Parameters:
- WORDSIZE, 64, datapath / PC width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards buffered and incoming results.
- in_valid  in  1  execute stage presents a branch.
- in_ready  out  1  resolver can accept this cycle.
- funct3  in  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- pc  in  WORDSIZE  address of the branch instruction.
- imm  in  WORDSIZE  sign-extended B-type offset.
- flag_equal, flag_not_equal, flag_greater, flag_less  in  1 each  signed flags from flagger.
- flag_u_equal, flag_u_greater, flag_u_less  in  1 each  unsigned flags from flagger.
- out_valid  out  1  result available.
- out_ready  in  1  fetch stage accepts result.
- out_taken  out  1  branch condition true.
- out_redirect  out  1  equals out_taken & ~out_illegal.
- out_next_pc  out  WORDSIZE  target if taken, else pc+4.
- out_illegal  out  1  funct3 is 010 or 011.

Behaviour:
- Reset: all outputs low, out_next_pc = 0, buffer count = 0, in_ready = 1.
- Condition decode:
  - BEQ = flag_equal; BNE = flag_not_equal.
  - BLT = flag_less; BGE = flag_greater | flag_equal.
  - BLTU = flag_u_less; BGEU = flag_u_greater | flag_u_equal.
  - Illegal funct3: taken = 0, illegal = 1, next_pc = pc+4.
- Arithmetic: target = pc + imm, pc+4 = pc + 4, both modulo 2^WORDSIZE; wrap-around is silent.
- Handshake:
  - Input transfers on in_valid & in_ready. Output transfers on out_valid & out_ready.
  - Payload must be held stable while valid is high and ready is low.
- Latency: 1 cycle. A result accepted in cycle N appears on the outputs in cycle N+1.
- Buffer, count 0..2:
  - in_ready = (count < 2). The ready path is registered; no combinational path from out_ready to in_ready.
  - Occupancy states:
    - EMPTY (0): accept → ONE.
    - ONE (1): accept without drain → FULL; drain without accept → EMPTY; simultaneous accept and drain → ONE.
    - FULL (2): no accept; drain → ONE.
  - Output order is strictly FIFO.
- flush:
  - Next count = 0, out_valid = 0.
  - A same-cycle input is dropped.
  - flush has priority over every other event.
- Reset mid-operation: everything is discarded immediately (asynchronous); no partial result is emitted after rst_n rises.
- Inconsistent flags (e.g. equal & less both high): the decode uses only the flag(s) listed above; no checking.

Optional Feature:
- Macro: BRANCH_RESOLVER_STATS_EN.
- When defined, adds two outputs:
  - stat_branches (32 bits): counts output transfers.
  - stat_taken (32 bits): counts output transfers with out_taken = 1.
- Both counters are cleared by reset only (not by flush) and saturate at 0xFFFF_FFFF.
- When undefined: the ports and counters are absent, and the remaining behaviour is identical.

Decomposition:
- Shared package holds:
  - funct3 constants: F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - Packed result struct: taken, redirect, next_pc, illegal.
  - Constant PC_STEP = 4.
- One sub-module: branch_skid_buffer, a parameterised 2-entry FIFO over the result struct that owns count, in_ready and out_valid.
- Condition decode and target adder stay in the top module.

Test Plan:
- BEQ, pc=0x1000, imm=0x20, flag_equal=1, out_ready=1 → next cycle out_valid=1, taken=1, redirect=1, next_pc=0x1020.
- BLT, pc=0x2000, imm=-8, flag_less=0 → taken=0, next_pc=0x2004. BGEU with flag_u_equal=1, imm=-8 → taken=1, next_pc=0x1FF8.
- funct3=010, pc=0x3000 → illegal=1, taken=0, redirect=0, next_pc=0x3004.
- out_ready=0 while 3 back-to-back branches are offered:
  - in_ready falls after 2 accepts; the third is held.
  - Raising out_ready drains results in order A, B, C, with no loss or duplication.
- Buffer FULL, flush=1 and in_valid=1 in the same cycle → next cycle out_valid=0, count 0, in_ready=1, and the new input is never emitted.
- pc=0xFFFF_FFFF_FFFF_FFFC, BNE taken, imm=8 → next_pc=0x4 (wrap). Assert rst_n=0 while FULL → outputs clear immediately.
